latch_rr_arbiter: RTL and testbench
===================================

# latch_rr_arbiter

Round-robin arbiter that shares a single 32-bit holding register among `NUM_REQ` producers. Each producer offers a word with a request; the block grants one winner per capture, holds the word with a valid flag until the consumer acknowledges, and tags it with the winner's index. It sits between several HLS-style producer ports and one downstream consumer that uses the `out_vld`/`out_ack` handshake.

## Interface
- `NUM_REQ`, 4: number of requesters, 1..16
- `DATA_W`, 32: data width
- `SRC_W`, `$clog2(NUM_REQ)` with a minimum of 1: width of the source index (localparam)
- `ap_clk` in 1: single clock, rising edge
- `ap_rst` in 1: asynchronous reset, active-high
- `req` in `NUM_REQ`: `req[i]` is high when requester i offers `data_in[i]`
- `data_in` in `NUM_REQ`x`DATA_W`: per-requester data, must be stable while `req[i]` is high
- `grant` out `NUM_REQ`: one-hot or zero; `grant[i]` is high in the cycle `data_in[i]` is captured
- `out_vld` out 1: the holding register holds an unacknowledged word
- `out_ack` in 1: the consumer accepts the word; it is sampled only while `out_vld` is high
- `data_out` out `DATA_W`: the held word
- `out_src` out `SRC_W`: index of the requester that supplied `data_out`

## Operation
- Two states: EMPTY (`out_vld`=0) and FULL (`out_vld`=1).
- Capture enable `cap` is high in either of these cases:
  - state is EMPTY and `req` is nonzero;
  - state is FULL, `out_ack` is high and `req` is nonzero. This case reloads back-to-back.
- Winner is the first requester with `req[k]` high, searching from `ptr` upward and wrapping modulo `NUM_REQ`.
- When `cap` is high, at the next edge:
  - `data_out` loads `data_in[k]`;
  - `out_src` loads k;
  - `out_vld` is set to 1;
  - `ptr` loads (k+1) mod `NUM_REQ`.
- FULL with `out_ack` high and `req` all zero: the next state is EMPTY, `out_vld` goes to 0, and `data_out` and `out_src` keep their values.
- FULL with `out_ack` low: nothing changes and `grant` is all zero. The held word is never overwritten.
- `out_ack` in the EMPTY state is ignored.
- `grant` is combinational and equals `cap` ANDed with one-hot(k). It depends only on `req`, `out_ack`, the state and `ptr`. It never depends on `data_in`.
- A requester may drop `req` before it is granted (withdraw); the arbiter then simply skips it.
- A requester that is granted and keeps `req` high is treated as offering a new word. It is considered again only after every other active requester has been served.
- Fairness: with all requesters continuously active, each one is granted exactly once in every `NUM_REQ` captures.
- With `NUM_REQ`=1: `ptr` is constant 0 and `out_src` is constant 0.

## Timing
- Reset values, applied asynchronously:
  - state EMPTY, `out_vld`=0;
  - `data_out`=0, `out_src`=0, `ptr`=0;
  - `grant`=0 while `ap_rst` is high.
- Latency: `grant` in cycle t gives `out_vld` and `data_out` updated in cycle t+1.
- Throughput: one word per cycle when `out_ack` is held high and requests are continuous. There is no bubble on a reload.
- A reset asserted mid-transaction discards the held word and returns `ptr` to 0. No grant is issued while reset is high.
- Deassertion of `ap_rst` is synchronous to `ap_clk` at the system level. The first capture is possible on the first edge after release.
- All outputs except `grant` are registered.

## Structure
- Package `latch_arb_pkg` contains:
  - `typedef enum logic {EMPTY, FULL} arb_state_t`;
  - the default-width constants `LATCH_ARB_DATA_W`=32 and `LATCH_ARB_NUM_REQ`=4.
- Sub-module `latch_rr_pick` (combinational):
  - inputs `req` and `ptr`;
  - outputs `any`, the one-hot `win` and the index `win_idx`;
  - implemented as a rotate, a priority encode, then an un-rotate.
- Top level `latch_rr_arbiter` contains:
  - the state register, the data and source registers and the pointer register;
  - the `cap` logic and the grant gating.

## Test plan
- Reset with `req`=0, then no stimulus for 5 cycles -> `out_vld`=0, `data_out`=0, `out_src`=0, `grant`=0 throughout.
- Single requester: `req`=4'b0100, `data_in[2]`=0xDEADBEEF, `out_ack`=0 -> `grant`=4'b0100 for one cycle. Next cycle `out_vld`=1, `data_out`=0xDEADBEEF, `out_src`=2. The outputs then hold for 10 cycles with no further grant.
- All four requesters active, data i = 0x100+i, `out_ack` held at 1 -> grants in the order 0,1,2,3,0,1 on consecutive cycles. `data_out` sequence is 0x100, 0x101, 0x102, 0x103, 0x100, 0x101, and `out_vld` stays 1.
- FULL with word 0xA5, `out_ack`=1 and `req`=0 -> next cycle `out_vld`=0 and `data_out` is still 0xA5. A later `out_ack` pulse while EMPTY has no effect.
- Withdraw and wrap: with `ptr`=3 and `req`=4'b1001, the grant goes to 3. If `req[0]` then drops before service and `req`=4'b0010 -> the next grant goes to 1 and `ptr` becomes 2.
- Assert `ap_rst` between edges while FULL with `out_src`=3 -> `out_vld`, `data_out` and `out_src` clear immediately. After release, `req`=4'b1111 is granted to 0 first.

Source files
------------

// File: rtl/latch_arb_pkg.sv
// latch_arb_pkg: shared state type and default widths for the latching round-robin arbiter
package latch_arb_pkg;
  typedef enum logic {EMPTY, FULL} arb_state_t;
  localparam int LATCH_ARB_DATA_W = 32;
  localparam int LATCH_ARB_NUM_REQ = 4;
endpackage

// File: rtl/latch_rr_arbiter_if.sv
// latch_rr_arbiter_if: producer requests/data in, held word with valid/ack handshake out
interface latch_rr_arbiter_if #(
  parameter int NUM_REQ = latch_arb_pkg::LATCH_ARB_NUM_REQ,
  parameter int DATA_W = latch_arb_pkg::LATCH_ARB_DATA_W,
  localparam int SRC_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0][DATA_W-1:0] data_in;
  logic out_vld;
  logic out_ack;
  logic [DATA_W-1:0] data_out;
  logic [SRC_W-1:0] out_src;
  modport master(input req, data_in, out_ack, output grant, out_vld, data_out, out_src);
  modport slave(output req, data_in, out_ack, input grant, out_vld, data_out, out_src);
endinterface

// File: rtl/latch_rr_pick.sv
// latch_rr_pick: first set request at or above ptr, wrapping; rotate, priority encode, un-rotate
module latch_rr_pick #(
  parameter int NUM_REQ = latch_arb_pkg::LATCH_ARB_NUM_REQ,
  localparam int SRC_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] win,
  output logic [SRC_W-1:0]   win_idx
);
  localparam logic [SRC_W:0] N = (SRC_W+1)'(NUM_REQ);
  logic [NUM_REQ-1:0] rot;
  logic [SRC_W-1:0] off;
  logic [SRC_W:0] sum;
  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (rot[i]) off = SRC_W'(i);
    sum = {1'b0, off} + {1'b0, ptr};
    win_idx = sum >= N ? SRC_W'(sum - N) : SRC_W'(sum);
    any = |req;
    win = any ? NUM_REQ'(1) << win_idx : '0;
  end
endmodule

// File: rtl/latch_rr_arbiter.sv
// latch_rr_arbiter: round-robin capture of one producer word into a held register with valid/ack
module latch_rr_arbiter import latch_arb_pkg::*; #(
  parameter int NUM_REQ = LATCH_ARB_NUM_REQ,
  parameter int DATA_W = LATCH_ARB_DATA_W,
  localparam int SRC_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input logic ap_clk,
  input logic ap_rst,
  latch_rr_arbiter_if.master bus
);
  localparam logic [SRC_W-1:0] LAST = SRC_W'(NUM_REQ - 1);
  arb_state_t state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SRC_W-1:0] src_q, src_d, ptr_q, ptr_d, k;
  logic [NUM_REQ-1:0] win;
  logic any, cap;
  latch_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(bus.req),
    .ptr(ptr_q),
    .any(any),
    .win(win),
    .win_idx(k)
  );
  // an ack while FULL frees the register this same cycle, so a pending request reloads with no bubble
  always_comb begin
    cap = (state_q == EMPTY || bus.out_ack) && any;
    state_d = cap ? FULL : bus.out_ack ? EMPTY : state_q;
    data_d = cap ? bus.data_in[k] : data_q;
    src_d = cap ? k : src_q;
    ptr_d = !cap ? ptr_q : k == LAST ? '0 : k + 1'b1;
  end
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) begin
      state_q <= EMPTY;
      data_q <= '0;
      src_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      src_q <= src_d;
      ptr_q <= ptr_d;
    end
  assign bus.grant = ap_rst ? '0 : cap ? win : '0;
  assign bus.out_vld = state_q == FULL;
  assign bus.data_out = data_q;
  assign bus.out_src = src_q;
endmodule

// File: tb/tb_latch_rr_arbiter.sv
// tb_latch_rr_arbiter: directed scenarios with hand-computed expectations
module tb_latch_rr_arbiter;
  logic ap_clk;
  logic ap_rst;
  int checks = 0;
  int errors = 0;
  latch_rr_arbiter_if #(.NUM_REQ(4), .DATA_W(32)) bus ();
  latch_rr_arbiter #(.NUM_REQ(4), .DATA_W(32)) dut (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus));
  initial ap_clk = 0;
  always #5 ap_clk = ~ap_clk;

  task automatic apply_reset();
    @(negedge ap_clk);
    ap_rst = 1; bus.req = '0; bus.out_ack = 0;
    @(negedge ap_clk);
    ap_rst = 0;
  endtask

  task automatic test_reset();
    bus.req = 4'b1111;
    #1;
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b expected 0000", bus.grant); end
    checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b expected 0", bus.out_vld); end
    bus.req = '0;
    @(negedge ap_clk);
    ap_rst = 0;
    repeat (5) begin
      @(negedge ap_clk);
      checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL idle_vld: got %b expected 0", bus.out_vld); end
      checks++; if (bus.data_out !== 32'h0) begin errors++; $display("FAIL idle_data: got %h expected 0", bus.data_out); end
      checks++; if (bus.out_src !== 2'd0) begin errors++; $display("FAIL idle_src: got %0d expected 0", bus.out_src); end
      checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL idle_grant: got %b expected 0000", bus.grant); end
    end
  endtask

  task automatic test_single();
    bus.data_in[2] = 32'hDEADBEEF;
    bus.req = 4'b0100;
    #1;
    checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", bus.grant); end
    repeat (11) begin
      @(negedge ap_clk);
      checks++; if (bus.out_vld !== 1'b1) begin errors++; $display("FAIL single_vld: got %b expected 1", bus.out_vld); end
      checks++; if (bus.data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h expected deadbeef", bus.data_out); end
      checks++; if (bus.out_src !== 2'd2) begin errors++; $display("FAIL single_src: got %0d expected 2", bus.out_src); end
      checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL single_hold_grant: got %b expected 0000", bus.grant); end
    end
    bus.req = '0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_g;
    apply_reset();
    for (int i = 0; i < 4; i++) bus.data_in[i] = 32'h100 + 32'(i);
    bus.req = 4'b1111;
    bus.out_ack = 1;
    for (int n = 0; n < 6; n++) begin
      exp_g = 4'b0001 << (n % 4);
      #1;
      checks++; if (bus.grant !== exp_g) begin errors++; $display("FAIL b2b_grant[%0d]: got %b expected %b", n, bus.grant, exp_g); end
      @(negedge ap_clk);
      checks++; if (bus.out_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld[%0d]: got %b expected 1", n, bus.out_vld); end
      checks++; if (bus.data_out !== 32'h100 + 32'(n % 4)) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", n, bus.data_out, 32'h100 + 32'(n % 4)); end
      checks++; if (bus.out_src !== 2'(n % 4)) begin errors++; $display("FAIL b2b_src[%0d]: got %0d expected %0d", n, bus.out_src, n % 4); end
    end
    bus.req = '0;
    bus.out_ack = 0;
  endtask

  task automatic test_drain();
    apply_reset();
    bus.data_in[0] = 32'hA5;
    bus.req = 4'b0001;
    @(negedge ap_clk);
    bus.req = '0;
    checks++; if (bus.out_vld !== 1'b1 || bus.data_out !== 32'hA5) begin errors++; $display("FAIL drain_load: got vld=%b data=%h expected vld=1 data=a5", bus.out_vld, bus.data_out); end
    bus.out_ack = 1;
    #1;
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL drain_grant: got %b expected 0000", bus.grant); end
    @(negedge ap_clk);
    checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL drain_vld: got %b expected 0", bus.out_vld); end
    checks++; if (bus.data_out !== 32'hA5) begin errors++; $display("FAIL drain_data: got %h expected a5", bus.data_out); end
    bus.out_ack = 0;
    @(negedge ap_clk);
    bus.out_ack = 1;
    @(negedge ap_clk);
    bus.out_ack = 0;
    checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL empty_ack_vld: got %b expected 0", bus.out_vld); end
    checks++; if (bus.data_out !== 32'hA5 || bus.out_src !== 2'd0) begin errors++; $display("FAIL empty_ack_hold: got data=%h src=%0d expected data=a5 src=0", bus.data_out, bus.out_src); end
  endtask

  task automatic test_withdraw_wrap();
    apply_reset();
    bus.data_in[0] = 32'h30; bus.data_in[1] = 32'h31; bus.data_in[2] = 32'h22; bus.data_in[3] = 32'h33;
    bus.out_ack = 1;
    bus.req = 4'b0100;
    #1;
    checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL wrap_setup_grant: got %b expected 0100", bus.grant); end
    @(negedge ap_clk);
    bus.req = 4'b1001;
    #1;
    checks++; if (bus.grant !== 4'b1000) begin errors++; $display("FAIL wrap_grant3: got %b expected 1000", bus.grant); end
    @(negedge ap_clk);
    checks++; if (bus.out_src !== 2'd3 || bus.data_out !== 32'h33) begin errors++; $display("FAIL wrap_src3: got src=%0d data=%h expected src=3 data=33", bus.out_src, bus.data_out); end
    bus.req = 4'b0010;
    #1;
    checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL withdraw_grant1: got %b expected 0010", bus.grant); end
    @(negedge ap_clk);
    checks++; if (bus.out_src !== 2'd1 || bus.data_out !== 32'h31) begin errors++; $display("FAIL withdraw_src1: got src=%0d data=%h expected src=1 data=31", bus.out_src, bus.data_out); end
    bus.req = 4'b1111;
    #1;
    checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL ptr2_grant: got %b expected 0100", bus.grant); end
    @(negedge ap_clk);
    checks++; if (bus.out_src !== 2'd2) begin errors++; $display("FAIL ptr2_src: got %0d expected 2", bus.out_src); end
    bus.req = '0;
    bus.out_ack = 0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.data_in[3] = 32'h77;
    bus.req = 4'b1000;
    @(negedge ap_clk);
    bus.req = '0;
    checks++; if (bus.out_vld !== 1'b1 || bus.out_src !== 2'd3) begin errors++; $display("FAIL arst_setup: got vld=%b src=%0d expected vld=1 src=3", bus.out_vld, bus.out_src); end
    #2;
    ap_rst = 1;
    bus.req = 4'b1111;
    #1;
    checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL arst_vld: got %b expected 0", bus.out_vld); end
    checks++; if (bus.data_out !== 32'h0) begin errors++; $display("FAIL arst_data: got %h expected 0", bus.data_out); end
    checks++; if (bus.out_src !== 2'd0) begin errors++; $display("FAIL arst_src: got %0d expected 0", bus.out_src); end
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL arst_grant: got %b expected 0000", bus.grant); end
    @(negedge ap_clk);
    ap_rst = 0;
    bus.data_in[0] = 32'h60;
    #1;
    checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL post_rst_grant: got %b expected 0001", bus.grant); end
    @(negedge ap_clk);
    checks++; if (bus.out_vld !== 1'b1 || bus.out_src !== 2'd0 || bus.data_out !== 32'h60) begin errors++; $display("FAIL post_rst_word: got vld=%b src=%0d data=%h expected vld=1 src=0 data=60", bus.out_vld, bus.out_src, bus.data_out); end
    bus.req = '0;
  endtask

  initial begin
    ap_rst = 1;
    bus.req = '0;
    bus.out_ack = 0;
    bus.data_in = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_drain();
    test_withdraw_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
